// File: rtl/cla_pkg.sv
// Definitions shared by the CLA prefix pipeline and its final sum stage:
// operand width, the per-bit prefix codes and the result entry layout.
package cla_pkg;

  localparam int W = 64;

  // Each prefix code is an ASCII letter: kill, propagate, generate.
  localparam logic [7:0] CODE_K = 8'h6B;
  localparam logic [7:0] CODE_P = 8'h70;
  localparam logic [7:0] CODE_G = 8'h67;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         code_err;
  } cla_entry_t;

  localparam int ENTRY_W = $bits(cla_entry_t);

  function automatic logic is_legal_code(input logic [7:0] code);
    return (code == CODE_K) || (code == CODE_P) || (code == CODE_G);
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Generic 2-entry FIFO. The producer cannot stall, so a push into a full FIFO
// with no pop in the same cycle is dropped and recorded in a sticky flag.
module skid_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req,
  input  logic [DW-1:0] wr_data,
  input  logic          pop_req,
  output logic          out_valid,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    count,
  output logic          drop
);

  logic [DW-1:0] mem_reg [2];
  logic [DW-1:0] hold_reg;
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic [1:0]    count_next;
  logic          drop_reg;
  logic          full;
  logic          pop;
  logic          push;
  logic          overrun;

  assign out_valid = (count_reg != 2'd0);
  assign full      = (count_reg == 2'd2);
  assign pop       = out_valid && pop_req;
  // A pop frees its slot in the same cycle, so a full FIFO can still accept.
  assign push      = push_req && (!full || pop);
  assign overrun   = push_req && full && !pop;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      drop_reg   <= 1'b0;
      hold_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
        hold_reg   <= mem_reg[rd_ptr_reg];
      end
      count_reg <= count_next;
      if (overrun) begin
        drop_reg <= 1'b1;
      end
    end
  end

  // Storage carries no reset; only slots marked valid by count are ever shown.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  // When empty, present the most recently popped entry instead of a stale slot.
  assign rd_data = out_valid ? mem_reg[rd_ptr_reg] : hold_reg;
  assign count   = count_reg;
  assign drop    = drop_reg;

endmodule

// File: rtl/cla_sum_stage.sv
// Final CLA stage: turns resolved prefix codes plus delayed operands into
// sum, carry-out and signed overflow, registered into a 2-entry output FIFO.
module cla_sum_stage
  import cla_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [W-1:0][7:0]   y,
  input  logic [W-1:0]        c,
  input  logic [W-1:0]        d,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        sum,
  output logic                cout,
  output logic                ovf,
  output logic                code_err,
  output logic                drop,
  output logic [1:0]          count
);

  logic [W-1:0] lane_g;
  logic [W-1:0] lane_legal;
  logic [W-1:0] carry;
  cla_entry_t   entry_next;
  cla_entry_t   head;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_lane
      assign lane_g[gi]     = (y[gi] == CODE_G);
      assign lane_legal[gi] = is_legal_code(y[gi]);
    end
  endgenerate

  // Carry-in is 0, so only a resolved generate produces a carry into the next bit.
  assign carry = {lane_g[W-2:0], 1'b0};

  always_comb begin
    entry_next          = '0;
    entry_next.sum      = c ^ d ^ carry;
    entry_next.cout     = lane_g[W-1];
    entry_next.ovf      = carry[W-1] ^ lane_g[W-1];
    entry_next.code_err = ~&lane_legal;
  end

  skid_fifo2 #(
    .DW(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_req (in_valid),
    .wr_data  (entry_next),
    .pop_req  (out_ready),
    .out_valid(out_valid),
    .rd_data  (head),
    .count    (count),
    .drop     (drop)
  );

  assign sum      = head.sum;
  assign cout     = head.cout;
  assign ovf      = head.ovf;
  assign code_err = head.code_err;

endmodule

// File: tb/tb_cla_sum_stage.sv
// Bench for cla_sum_stage: directed corner cases plus a randomized run checked
// against an arithmetic reference and a queue-based output buffer model.
module tb_cla_sum_stage;

  localparam int W = 64;
  localparam logic [7:0] K = 8'h6B;
  localparam logic [7:0] P = 8'h70;
  localparam logic [7:0] G = 8'h67;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [W-1:0][7:0] y;
  logic [W-1:0]      c = '0;
  logic [W-1:0]      d = '0;
  logic              out_valid;
  logic [W-1:0]      sum;
  logic              cout;
  logic              ovf;
  logic              code_err;
  logic              drop;
  logic [1:0]        count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_sum_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .y        (y),
    .c        (c),
    .d        (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .code_err (code_err),
    .drop     (drop),
    .count    (count)
  );

  task automatic set_all(input logic [7:0] code);
    for (int i = 0; i < W; i++) y[i] = code;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] cc, input logic [W-1:0] dd,
                       input logic rdy);
    in_valid  = v;
    c         = cc;
    d         = dd;
    out_ready = rdy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    #3;
    total++;
    if ({out_valid, count, drop, sum, cout, ovf, code_err} !== '0) begin
      bad++;
      $display("FAIL reset_state got v=%0b cnt=%0d drop=%0b sum=%h co=%0b ovf=%0b err=%0b want all 0",
               out_valid, count, drop, sum, cout, ovf, code_err);
    end
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_zero;
    set_all(K);
    drive(1'b1, '0, '0, 1'b1);
    tick();
    total++;
    if ({out_valid, sum, cout, ovf, code_err} !== {1'b1, 64'h0, 3'b000}) begin
      bad++;
      $display("FAIL zero_case got v=%0b sum=%h co=%0b ovf=%0b err=%0b want v=1 sum=0 co=0 ovf=0 err=0",
               out_valid, sum, cout, ovf, code_err);
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    total++;
    if ({out_valid, count} !== 3'b000) begin
      bad++;
      $display("FAIL zero_drain got v=%0b cnt=%0d want v=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_ripple;
    set_all(G);
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    tick();
    total++;
    if ({out_valid, sum, cout, ovf} !== {1'b1, 64'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL full_ripple got v=%0b sum=%h co=%0b ovf=%0b want v=1 sum=0 co=1 ovf=0",
               out_valid, sum, cout, ovf);
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
  endtask

  task automatic test_overflow;
    set_all(G);
    y[63] = P;
    drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    tick();
    total++;
    if ({out_valid, sum, cout, ovf, code_err} !== {1'b1, 64'h8000_0000_0000_0000, 3'b010}) begin
      bad++;
      $display("FAIL signed_ovf got v=%0b sum=%h co=%0b ovf=%0b err=%0b want v=1 sum=8000000000000000 co=0 ovf=1 err=0",
               out_valid, sum, cout, ovf, code_err);
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
  endtask

  task automatic test_backpressure;
    logic [1:0] exp_cnt [3];
    logic       exp_drop [3];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd2;
    exp_drop[0] = 1'b0; exp_drop[1] = 1'b0; exp_drop[2] = 1'b1;
    do_reset();
    set_all(K);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(i + 1), '0, 1'b0);
      tick();
      total++;
      if ({count, drop, sum} !== {exp_cnt[i], exp_drop[i], 64'h1}) begin
        bad++;
        $display("FAIL backpressure_push%0d got cnt=%0d drop=%0b sum=%h want cnt=%0d drop=%0b sum=1",
                 i, count, drop, sum, exp_cnt[i], exp_drop[i]);
      end
    end
    drive(1'b0, '0, '0, 1'b1);
    #1;
    total++;
    if ({out_valid, sum} !== {1'b1, 64'h1}) begin
      bad++;
      $display("FAIL backpressure_head1 got v=%0b sum=%h want v=1 sum=1", out_valid, sum);
    end
    tick();
    total++;
    if ({out_valid, count, sum} !== {1'b1, 2'd1, 64'h2}) begin
      bad++;
      $display("FAIL backpressure_head2 got v=%0b cnt=%0d sum=%h want v=1 cnt=1 sum=2",
               out_valid, count, sum);
    end
    tick();
    total++;
    if ({out_valid, count, drop, sum} !== {1'b0, 2'd0, 1'b1, 64'h2}) begin
      bad++;
      $display("FAIL backpressure_empty got v=%0b cnt=%0d drop=%0b sum=%h want v=0 cnt=0 drop=1 sum=2",
               out_valid, count, drop, sum);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_all(K);
    drive(1'b1, 64'd10, '0, 1'b0);
    tick();
    drive(1'b1, 64'd11, '0, 1'b0);
    tick();
    total++;
    if ({count, sum} !== {2'd2, 64'd10}) begin
      bad++;
      $display("FAIL b2b_fill got cnt=%0d sum=%0d want cnt=2 sum=10", count, sum);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'(12 + i), '0, 1'b1);
      tick();
      total++;
      if ({count, drop, sum} !== {2'd2, 1'b0, 64'(11 + i)}) begin
        bad++;
        $display("FAIL b2b_pushpop%0d got cnt=%0d drop=%0b sum=%0d want cnt=2 drop=0 sum=%0d",
                 i, count, drop, sum, 11 + i);
      end
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    total++;
    if ({count, sum} !== {2'd1, 64'd13}) begin
      bad++;
      $display("FAIL b2b_drain1 got cnt=%0d sum=%0d want cnt=1 sum=13", count, sum);
    end
    tick();
    total++;
    if ({out_valid, count, drop, sum} !== {1'b0, 2'd0, 1'b0, 64'd13}) begin
      bad++;
      $display("FAIL b2b_drain2 got v=%0b cnt=%0d drop=%0b sum=%0d want v=0 cnt=0 drop=0 sum=13",
               out_valid, count, drop, sum);
    end
  endtask

  task automatic test_code_err_reset;
    do_reset();
    set_all(K);
    y[5] = 8'h00;
    drive(1'b1, 64'h1234, '0, 1'b1);
    tick();
    total++;
    if ({out_valid, sum, code_err} !== {1'b1, 64'h1234, 1'b1}) begin
      bad++;
      $display("FAIL code_err_set got v=%0b sum=%h err=%0b want v=1 sum=1234 err=1",
               out_valid, sum, code_err);
    end
    set_all(K);
    drive(1'b1, 64'h55, '0, 1'b1);
    tick();
    total++;
    if ({count, sum, code_err} !== {2'd1, 64'h55, 1'b0}) begin
      bad++;
      $display("FAIL code_err_next got cnt=%0d sum=%h err=%0b want cnt=1 sum=55 err=0",
               count, sum, code_err);
    end
    drive(1'b1, 64'h66, '0, 1'b0);
    tick();
    drive(1'b1, 64'h77, '0, 1'b0);
    tick();
    total++;
    if ({count, drop} !== {2'd2, 1'b1}) begin
      bad++;
      $display("FAIL pre_reset_full got cnt=%0d drop=%0b want cnt=2 drop=1", count, drop);
    end
    drive(1'b1, 64'h88, '0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid, count, drop, sum, code_err} !== '0) begin
      bad++;
      $display("FAIL async_reset got v=%0b cnt=%0d drop=%0b sum=%h err=%0b want all 0",
               out_valid, count, drop, sum, code_err);
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    total++;
    if ({out_valid, count} !== 3'b000) begin
      bad++;
      $display("FAIL post_reset_idle got v=%0b cnt=%0d want v=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_random;
    exp_t         q[$];
    exp_t         last;
    exp_t         e;
    exp_t         head;
    logic         mdrop;
    logic         v, rdy, pop, push;
    logic [W-1:0] cc, dd;
    logic [W:0]   s65;
    logic         co_i;
    int           sz, lane;
    do_reset();
    last  = '0;
    mdrop = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v   = ($urandom % 4) != 0;
      rdy = ($urandom % 3) != 0;
      cc  = {$urandom, $urandom};
      dd  = ($urandom % 4 == 0) ? ~cc + 64'(($urandom % 3)) : {$urandom, $urandom};
      s65 = {1'b0, cc} + {1'b0, dd};
      e.sum  = s65[W-1:0];
      e.cout = s65[W];
      e.ovf  = (cc[W-1] == dd[W-1]) && (s65[W-1] != cc[W-1]);
      e.err  = 1'b0;
      // Resolved code: G where the true carry out of the bit is 1, else K or P.
      for (int i = 0; i < W; i++) begin
        co_i = (i == W - 1) ? s65[W] : (s65[i+1] ^ cc[i+1] ^ dd[i+1]);
        y[i] = co_i ? G : (($urandom % 2) ? K : P);
      end
      lane = $urandom_range(0, W - 1);
      if (($urandom % 6 == 0) && (y[lane] != G)) begin
        y[lane] = 8'h00;
        e.err   = 1'b1;
      end
      sz   = q.size();
      pop  = (sz > 0) && rdy;
      push = v && ((sz < 2) || pop);
      if (v && (sz == 2) && !pop) mdrop = 1'b1;
      if (pop) last = q.pop_front();
      if (push) q.push_back(e);
      drive(v, cc, dd, rdy);
      tick();
      head = (q.size() > 0) ? q[0] : last;
      total++;
      if ({out_valid, count} !== {q.size() > 0, 2'(q.size())}) begin
        bad++;
        $display("FAIL rand_occupancy cyc=%0d got v=%0b cnt=%0d want v=%0b cnt=%0d",
                 cyc, out_valid, count, q.size() > 0, q.size());
      end
      total++;
      if (drop !== mdrop) begin
        bad++;
        $display("FAIL rand_drop cyc=%0d got %0b want %0b", cyc, drop, mdrop);
      end
      total++;
      if ({sum, cout, ovf, code_err} !== head) begin
        bad++;
        $display("FAIL rand_result cyc=%0d got sum=%h co=%0b ovf=%0b err=%0b want sum=%h co=%0b ovf=%0b err=%0b",
                 cyc, sum, cout, ovf, code_err, head.sum, head.cout, head.ovf, head.err);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    set_all(K);
    test_reset();
    test_zero();
    test_ripple();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_code_err_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
